// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: data-hazard detection, branch flush, memory-wait freeze
// with timeout-to-halt, and saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             fwd_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_freeze,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W:0]   TIMEOUT_C = (WAIT_W + 1)'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [WAIT_W:0]   wait_inc_s;
    logic              mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic exe_hit_s, mem_hit_s, hazard_s;
    logic pc_freeze_s, ifid_flush_s, idex_flush_s, pipe_freeze_s;

    // Source-operand match against EXE/MEM destinations and hazard decision.
    always_comb begin
        exe_hit_s = (id_src1 == exe_dest) || (id_two_src && (id_src2 == exe_dest));
        mem_hit_s = (id_src1 == mem_dest) || (id_two_src && (id_src2 == mem_dest));
        if (fwd_en) begin
            // With forwarding only a load result in EXE arrives too late.
            hazard_s = exe_mem_r_en && exe_hit_s;
        end else begin
            hazard_s = (exe_wb_en && exe_hit_s) || (mem_wb_en && mem_hit_s);
        end
    end

    assign wait_inc_s = {1'b0, wait_cnt_q} + {{WAIT_W{1'b0}}, 1'b1};

    // Next-state and raw control outputs of the RUN / MEM_WAIT / HALT machine.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        pc_freeze_s   = 1'b0;
        ifid_flush_s  = 1'b0;
        idex_flush_s  = 1'b0;
        pipe_freeze_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    pc_freeze_s   = 1'b1;
                    pipe_freeze_s = 1'b1;
                    state_d       = ST_MEM_WAIT;
                    wait_cnt_d    = WAIT_ONE;
                end else if (branch_taken) begin
                    ifid_flush_s = 1'b1;
                    idex_flush_s = 1'b1;
                end else if (hazard_s) begin
                    pc_freeze_s  = 1'b1;
                    idex_flush_s = 1'b1;
                end else begin
                    pc_freeze_s = 1'b0;
                end
            end
            ST_MEM_WAIT: begin
                pc_freeze_s   = 1'b1;
                pipe_freeze_s = 1'b1;
                if (mem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = {WAIT_W{1'b0}};
                end else begin
                    wait_cnt_d = wait_inc_s[WAIT_W-1:0];
                    if (wait_inc_s >= TIMEOUT_C) begin
                        state_d       = ST_HALT;
                        mem_timeout_d = 1'b1;
                    end else begin
                        state_d = ST_MEM_WAIT;
                    end
                end
            end
            ST_HALT: begin
                pc_freeze_s   = 1'b1;
                pipe_freeze_s = 1'b1;
                mem_timeout_d = 1'b1;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = {WAIT_W{1'b0}};
            end
        endcase
    end

    // Reset forces every control output low in the same cycle.
    assign pc_freeze   = pc_freeze_s   & ~rst;
    assign ifid_flush  = ifid_flush_s  & ~rst;
    assign idex_flush  = idex_flush_s  & ~rst;
    assign pipe_freeze = pipe_freeze_s & ~rst;

    // Saturating performance counter next-state values.
    always_comb begin
        if (pc_freeze && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (ifid_flush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State, wait counter, timeout flag and performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= {WAIT_W{1'b0}};
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= {CNT_W{1'b0}};
            flush_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the saturating stall and flush performance counters.
REQ-002 SHALL have parameter TIMEOUT, default 64: number of consecutive memory-wait cycles that forces the HALT state.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port id_src1, input, 4: first source register of the instruction in ID.
REQ-006 SHALL have port id_src2, input, 4: second source register of the instruction in ID.
REQ-007 SHALL have port id_two_src, input, 1: the ID instruction reads id_src2.
REQ-008 SHALL have ports exe_dest (input, 4), exe_wb_en (input, 1) and exe_mem_r_en (input, 1): destination, writeback enable and load flag of the instruction in EXE.
REQ-009 SHALL have ports mem_dest (input, 4) and mem_wb_en (input, 1): destination and writeback enable of the instruction in MEM.
REQ-010 SHALL have port fwd_en, input, 1: forwarding unit active.
REQ-011 SHALL have port branch_taken, input, 1: the branch resolved taken in EXE.
REQ-012 SHALL have ports mem_req (input, 1) and mem_ready (input, 1): the MEM stage accesses data memory, and the memory has completed the access.
REQ-013 SHALL have port pc_freeze, output, 1: hold the PC and the IF/ID register.
REQ-014 SHALL have port ifid_flush, output, 1: clear the IF/ID register.
REQ-015 SHALL have port idex_flush, output, 1: clear the ID/EX register, inserting a bubble.
REQ-016 SHALL have port pipe_freeze, output, 1: hold the ID/EX, EX/MEM and MEM/WB registers.
REQ-017 SHALL have port mem_timeout, output, 1: sticky error flag.
REQ-018 SHALL have ports stall_cnt and flush_cnt, output, CNT_W each: performance counters.

Function
REQ-019 SHALL compute hazard combinationally as follows:
- fwd_en=0: hazard=1 if a used source equals exe_dest while exe_wb_en=1, or equals mem_dest while mem_wb_en=1.
- fwd_en=1: hazard=1 only if exe_mem_r_en=1 and a used source equals exe_dest.
- id_src1 is always a used source; id_src2 is a used source only when id_two_src=1.
REQ-020 SHALL implement a state machine with states RUN, MEM_WAIT and HALT, plus an internal wait counter wait_cnt of width ceil(log2(TIMEOUT+1)).
REQ-021 In RUN, SHALL apply these priorities, evaluated in the same cycle:
- First: if mem_req=1 and mem_ready=0, assert pc_freeze=1 and pipe_freeze=1, keep both flushes at 0, and go to MEM_WAIT with wait_cnt=1.
- Second: if branch_taken=1, assert ifid_flush=1 and idex_flush=1 for that cycle only, with no freeze.
- Third: if hazard=1, assert pc_freeze=1 and idex_flush=1.
- Otherwise: all control outputs are 0.
REQ-022 In MEM_WAIT, SHALL assert pc_freeze=1 and pipe_freeze=1 with both flushes at 0, and SHALL ignore branch_taken and hazard.
REQ-023 In MEM_WAIT with mem_ready=1, SHALL still assert both freezes in that cycle, clear wait_cnt and return to RUN.
REQ-024 In MEM_WAIT with mem_ready=0, SHALL increment wait_cnt; when wait_cnt==TIMEOUT, it SHALL go to HALT and set mem_timeout=1.
REQ-025 In HALT, SHALL hold pc_freeze=1, pipe_freeze=1 and mem_timeout=1 until rst, ignoring all other inputs.
REQ-026 SHALL increment stall_cnt once per cycle in which pc_freeze=1, saturating at all-ones.
REQ-027 SHALL increment flush_cnt once per cycle in which ifid_flush=1, saturating at all-ones.
REQ-028 SHALL give the control outputs zero latency, i.e. combinational from the current state and inputs; counters and mem_timeout SHALL be registered.
REQ-029 SHALL NOT let a mem_req with mem_ready=1 in the same cycle cause a stall.

Reset
REQ-030 With rst=1 at a rising edge, SHALL set state to RUN and clear wait_cnt, mem_timeout, stall_cnt and flush_cnt.
REQ-031 While rst=1, SHALL drive pc_freeze, ifid_flush, idex_flush and pipe_freeze to 0.
REQ-032 A reset asserted in MEM_WAIT or HALT SHALL take effect at the next edge, with no residual freeze afterwards.

Verification
REQ-033 Load-use: fwd_en=1, exe_mem_r_en=1, exe_wb_en=1, exe_dest=3, id_src1=3 -> pc_freeze=1, idex_flush=1, stall_cnt +1; the same with id_src2=3 and id_two_src=0 -> no stall.
REQ-034 No forwarding: fwd_en=0, mem_wb_en=1, mem_dest=5, id_src2=5, id_two_src=1 -> stall; fwd_en=1 with the same inputs -> no stall.
REQ-035 Branch plus hazard in the same cycle -> ifid_flush=1, idex_flush=1, pc_freeze=0, flush_cnt +1, stall_cnt unchanged.
REQ-036 Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> pc_freeze=1 and pipe_freeze=1 for 4 cycles, state back to RUN, stall_cnt +4; branch_taken pulsed during the wait -> no flush.
REQ-037 Timeout: TIMEOUT=4, mem_ready held at 0 -> HALT with mem_timeout=1 after the 4th wait cycle; mem_ready=1 afterwards -> still frozen; rst -> all outputs 0.
REQ-038 Saturation: CNT_W=2, 5 stall cycles -> stall_cnt=3.
